// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, FSM states,
// instruction classes and strobe bit positions.
// No logic or latency of its own; purely declarations plus one helper function.
// STEPWAIT exists only when CU_SINGLE_STEP_EN is defined.
package cu_pkg;

  // Opcodes live in IR[BITS-1:BITS-5]
  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  typedef enum logic [3:0] {
    FETCH0, FETCH1, FETCH2,
    EX3, EX4, EX5, EX6, EX7,
    STOPPED, HALTED
`ifdef CU_SINGLE_STEP_EN
    , STEPWAIT
`endif
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_LD, CLS_LDI, CLS_ST, CLS_ALU_R, CLS_ALU_I, CLS_MULDIV,
    CLS_UNARY, CLS_BR, CLS_JR, CLS_IN, CLS_OUT, CLS_HALT, CLS_ILLEGAL
  } cls_e;

  // ld_en bit positions
  localparam int LD_CONIN    = 0;
  localparam int LD_PCIN     = 1;
  localparam int LD_IRIN     = 2;
  localparam int LD_RYIN     = 3;
  localparam int LD_RZIN     = 4;
  localparam int LD_MARIN    = 5;
  localparam int LD_HILOIN   = 6;
  localparam int LD_OUTPUTIN = 7;
  localparam int LD_INTERIN  = 8;
  localparam int LD_MDRIN    = 9;

  // drv_en bit positions
  localparam int DRV_INPUTOUT = 0;
  localparam int DRV_MDROUT   = 1;
  localparam int DRV_HILOOUT  = 2;
  localparam int DRV_RZOUT    = 3;
  localparam int DRV_PCOUT    = 4;
  localparam int DRV_COUT     = 5;
  localparam int DRV_INTEROUT = 6;
  localparam int DRV_BAOUT    = 7;

  // reg_sel bit positions
  localparam int RS_GRA  = 0;
  localparam int RS_GRB  = 1;
  localparam int RS_GRC  = 2;
  localparam int RS_ROUT = 3;
  localparam int RS_RIN  = 4;

  // alu_op bit positions
  localparam int ALU_ADD    = 0;
  localparam int ALU_SUB    = 1;
  localparam int ALU_MUL    = 2;
  localparam int ALU_DIV    = 3;
  localparam int ALU_SHR    = 4;
  localparam int ALU_SHL    = 5;
  localparam int ALU_ROR    = 6;
  localparam int ALU_ROL    = 7;
  localparam int ALU_AND    = 8;
  localparam int ALU_OR     = 9;
  localparam int ALU_NEGATE = 10;
  localparam int ALU_NOT    = 11;
  localparam int ALU_INCPC  = 12;

  // Final execute state of each instruction class
  function automatic state_e last_state(input cls_e c);
    case (c)
      CLS_LD, CLS_ST:                              return EX7;
      CLS_BR:                                      return EX6;
      CLS_LDI, CLS_ALU_R, CLS_ALU_I, CLS_MULDIV:   return EX5;
      CLS_UNARY:                                   return EX4;
      default:                                     return EX3;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer (master) and the datapath (slave).
// No latency; wires only. No backpressure: strobes are unconditional levels.
// Ports: IR/CON/stop/step into the sequencer; strobe groups, Read/Write, run, illegal_op out.
interface control_sequencer_if #(parameter int BITS = 32);
  logic [BITS-1:0] IR;
  logic            CON;
  logic            stop;
  logic            step;
  logic [9:0]      ld_en;
  logic [7:0]      drv_en;
  logic [4:0]      reg_sel;
  logic [12:0]     alu_op;
  logic            Read;
  logic            Write;
  logic            run;
  logic            illegal_op;

  modport master (
    input  IR, CON, stop, step,
    output ld_en, drv_en, reg_sel, alu_op, Read, Write, run, illegal_op
  );

  modport slave (
    output IR, CON, stop, step,
    input  ld_en, drv_en, reg_sel, alu_op, Read, Write, run, illegal_op
  );
endinterface

// File: rtl/cu_decode.sv
// Opcode decoder: maps the 5-bit opcode to an instruction class and ALU op one-hot.
// Purely combinational, zero latency. No backpressure.
// Ports: opcode in; cls (instruction class) and alu_onehot (at most one bit set) out.
module cu_decode
  import cu_pkg::*;
(
  input  logic [4:0]  opcode,
  output cls_e        cls,
  output logic [12:0] alu_onehot
);

  always_comb begin
    cls        = CLS_ILLEGAL;
    alu_onehot = '0;
    case (opcode)
      OP_LD:   cls = CLS_LD;
      OP_LDI:  cls = CLS_LDI;
      OP_ST:   cls = CLS_ST;
      OP_ADD:  begin cls = CLS_ALU_R;  alu_onehot[ALU_ADD]    = 1'b1; end
      OP_SUB:  begin cls = CLS_ALU_R;  alu_onehot[ALU_SUB]    = 1'b1; end
      OP_SHR:  begin cls = CLS_ALU_R;  alu_onehot[ALU_SHR]    = 1'b1; end
      OP_SHL:  begin cls = CLS_ALU_R;  alu_onehot[ALU_SHL]    = 1'b1; end
      OP_ROR:  begin cls = CLS_ALU_R;  alu_onehot[ALU_ROR]    = 1'b1; end
      OP_ROL:  begin cls = CLS_ALU_R;  alu_onehot[ALU_ROL]    = 1'b1; end
      OP_AND:  begin cls = CLS_ALU_R;  alu_onehot[ALU_AND]    = 1'b1; end
      OP_OR:   begin cls = CLS_ALU_R;  alu_onehot[ALU_OR]     = 1'b1; end
      OP_ADDI: begin cls = CLS_ALU_I;  alu_onehot[ALU_ADD]    = 1'b1; end
      OP_ANDI: begin cls = CLS_ALU_I;  alu_onehot[ALU_AND]    = 1'b1; end
      OP_ORI:  begin cls = CLS_ALU_I;  alu_onehot[ALU_OR]     = 1'b1; end
      OP_MUL:  begin cls = CLS_MULDIV; alu_onehot[ALU_MUL]    = 1'b1; end
      OP_DIV:  begin cls = CLS_MULDIV; alu_onehot[ALU_DIV]    = 1'b1; end
      OP_NEG:  begin cls = CLS_UNARY;  alu_onehot[ALU_NEGATE] = 1'b1; end
      OP_NOT:  begin cls = CLS_UNARY;  alu_onehot[ALU_NOT]    = 1'b1; end
      OP_BR:   cls = CLS_BR;
      OP_JR:   cls = CLS_JR;
      OP_IN:   cls = CLS_IN;
      OP_OUT:  cls = CLS_OUT;
      OP_NOP:  cls = CLS_NOP;
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit: one FSM state per clk, strobes decoded from state.
// Latency: strobes for a state are valid for the whole cycle that state is held; 3 fetch + 1..5 execute cycles.
// No backpressure; stop (level) parks the FSM between instructions. Optional CU_SINGLE_STEP_EN adds STEPWAIT.
// Ports: clk, reset (async active-low), cu (master modport: IR/CON/stop/step in; strobes, run, illegal_op out).
module control_sequencer
  import cu_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  control_sequencer_if.master  cu
);

  state_e      state_q, state_d;
  cls_e        cls;
  logic [12:0] alu_sel;
  logic        seq_end;

  logic [9:0]  ld;
  logic [7:0]  drv;
  logic [4:0]  rsel;
  logic [12:0] alu;
  logic        rd, wr, run_s, ill;

  // IR only changes at the end of FETCH2, so decoding it live is stable across the execute states.
  cu_decode u_decode (
    .opcode     (cu.IR[BITS-1 -: 5]),
    .cls        (cls),
    .alu_onehot (alu_sel)
  );

  assign seq_end = (state_q == last_state(cls));

`ifdef CU_SINGLE_STEP_EN
  logic step_q;
  logic step_rise;
  logic unused_bits;
  assign unused_bits = ^cu.IR[BITS-6:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= cu.step;
  end
  assign step_rise = cu.step & ~step_q;
`else
  logic unused_bits;
  assign unused_bits = ^{cu.step, cu.IR[BITS-6:0]};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH0: state_d = FETCH1;
      FETCH1: state_d = FETCH2;
      FETCH2: state_d = EX3;
      EX3, EX4, EX5, EX6, EX7: begin
        if (seq_end) begin
          // halt wins over stop; stop is only honoured at an instruction boundary
          if (cls == CLS_HALT)  state_d = HALTED;
          else if (cu.stop)     state_d = STOPPED;
`ifdef CU_SINGLE_STEP_EN
          else                  state_d = STEPWAIT;
`else
          else                  state_d = FETCH0;
`endif
        end else begin
          case (state_q)
            EX3:     state_d = EX4;
            EX4:     state_d = EX5;
            EX5:     state_d = EX6;
            default: state_d = EX7;
          endcase
        end
      end
      STOPPED: if (!cu.stop) state_d = FETCH0;
      HALTED:  state_d = HALTED;
`ifdef CU_SINGLE_STEP_EN
      STEPWAIT: begin
        if (cu.stop)        state_d = STOPPED;
        else if (step_rise) state_d = FETCH0;
      end
`endif
      default: state_d = FETCH0;
    endcase
  end

  always_comb begin
    ld    = '0;
    drv   = '0;
    rsel  = '0;
    alu   = '0;
    rd    = 1'b0;
    wr    = 1'b0;
    run_s = 1'b1;
    ill   = 1'b0;
    case (state_q)
      FETCH0: begin
        drv[DRV_PCOUT] = 1'b1; ld[LD_MARIN] = 1'b1; alu[ALU_INCPC] = 1'b1; ld[LD_RZIN] = 1'b1;
      end
      FETCH1: begin
        drv[DRV_RZOUT] = 1'b1; ld[LD_PCIN] = 1'b1; rd = 1'b1; ld[LD_MDRIN] = 1'b1;
      end
      FETCH2: begin
        drv[DRV_MDROUT] = 1'b1; ld[LD_IRIN] = 1'b1;
      end
      EX3: begin
        case (cls)
          CLS_LD, CLS_LDI, CLS_ST: begin
            rsel[RS_GRB] = 1'b1; drv[DRV_BAOUT] = 1'b1; ld[LD_RYIN] = 1'b1;
          end
          CLS_ALU_R, CLS_ALU_I: begin
            rsel[RS_GRB] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_RYIN] = 1'b1;
          end
          CLS_MULDIV: begin
            rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_RYIN] = 1'b1;
          end
          CLS_UNARY: begin
            rsel[RS_GRB] = 1'b1; rsel[RS_ROUT] = 1'b1; alu = alu_sel; ld[LD_RZIN] = 1'b1;
          end
          CLS_BR: begin
            rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_CONIN] = 1'b1;
          end
          CLS_JR: begin
            rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_PCIN] = 1'b1;
          end
          CLS_IN: begin
            drv[DRV_INPUTOUT] = 1'b1; rsel[RS_GRA] = 1'b1; rsel[RS_RIN] = 1'b1;
          end
          CLS_OUT: begin
            rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_OUTPUTIN] = 1'b1;
          end
          CLS_ILLEGAL: ill = 1'b1;
          default: ;
        endcase
      end
      EX4: begin
        case (cls)
          CLS_LD, CLS_LDI, CLS_ST: begin
            drv[DRV_COUT] = 1'b1; alu[ALU_ADD] = 1'b1; ld[LD_RZIN] = 1'b1;
          end
          CLS_ALU_R: begin
            rsel[RS_GRC] = 1'b1; rsel[RS_ROUT] = 1'b1; alu = alu_sel; ld[LD_RZIN] = 1'b1;
          end
          CLS_ALU_I: begin
            drv[DRV_COUT] = 1'b1; alu = alu_sel; ld[LD_RZIN] = 1'b1;
          end
          CLS_MULDIV: begin
            rsel[RS_GRB] = 1'b1; rsel[RS_ROUT] = 1'b1; alu = alu_sel; ld[LD_RZIN] = 1'b1;
          end
          CLS_UNARY: begin
            drv[DRV_RZOUT] = 1'b1; rsel[RS_GRA] = 1'b1; rsel[RS_RIN] = 1'b1;
          end
          CLS_BR: begin
            drv[DRV_PCOUT] = 1'b1; ld[LD_RYIN] = 1'b1;
          end
          default: ;
        endcase
      end
      EX5: begin
        case (cls)
          CLS_LD, CLS_ST: begin
            drv[DRV_RZOUT] = 1'b1; ld[LD_MARIN] = 1'b1;
          end
          CLS_LDI, CLS_ALU_R, CLS_ALU_I: begin
            drv[DRV_RZOUT] = 1'b1; rsel[RS_GRA] = 1'b1; rsel[RS_RIN] = 1'b1;
          end
          CLS_MULDIV: begin
            drv[DRV_RZOUT] = 1'b1; ld[LD_HILOIN] = 1'b1;
          end
          CLS_BR: begin
            drv[DRV_COUT] = 1'b1; alu[ALU_ADD] = 1'b1; ld[LD_RZIN] = 1'b1;
          end
          default: ;
        endcase
      end
      EX6: begin
        case (cls)
          CLS_LD: begin
            rd = 1'b1; ld[LD_MDRIN] = 1'b1;
          end
          CLS_ST: begin
            rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_MDRIN] = 1'b1;
          end
          CLS_BR: begin
            // branch target only committed when the latched condition holds
            drv[DRV_RZOUT] = 1'b1; ld[LD_PCIN] = cu.CON;
          end
          default: ;
        endcase
      end
      EX7: begin
        case (cls)
          CLS_LD: begin
            drv[DRV_MDROUT] = 1'b1; rsel[RS_GRA] = 1'b1; rsel[RS_RIN] = 1'b1;
          end
          CLS_ST: wr = 1'b1;
          default: ;
        endcase
      end
      STOPPED, HALTED: run_s = 1'b0;
`ifdef CU_SINGLE_STEP_EN
      STEPWAIT: run_s = 1'b0;
`endif
      default: ;
    endcase
  end

  // While reset is held every strobe is forced low at once, so an aborted store never writes.
  assign cu.ld_en      = reset ? ld   : '0;
  assign cu.drv_en     = reset ? drv  : '0;
  assign cu.reg_sel    = reset ? rsel : '0;
  assign cu.alu_op     = reset ? alu  : '0;
  assign cu.Read       = reset & rd;
  assign cu.Write      = reset & wr;
  assign cu.illegal_op = reset & ill;
  assign cu.run        = ~reset | run_s;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed program plus random instruction stream.
// Compares the full strobe vector every cycle against an opcode/step reference table.
// Drives IR as the datapath would (loaded after the IRin cycle) and toggles stop/CON/step.
module tb_control_sequencer;

  localparam int CONIN = 0, PCIN = 1, IRIN = 2, RYIN = 3, RZIN = 4, MARIN = 5,
                 HILOIN = 6, OUTPUTIN = 7, MDRIN = 9;
  localparam int INPUTOUT = 0, MDROUT = 1, RZOUT = 3, PCOUT = 4, COUT = 5, BAOUT = 7;
  localparam int GRA = 0, GRB = 1, GRC = 2, ROUT = 3, RIN = 4;
  localparam int A_ADD = 0, A_INCPC = 12;

  typedef struct packed {
    logic [9:0]  ld;
    logic [7:0]  dr;
    logic [4:0]  rs;
    logic [12:0] al;
    logic        rd;
    logic        wr;
    logic        run;
    logic        ill;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  control_sequencer_if #(.BITS(32)) cu_if ();

  control_sequencer #(.BITS(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .cu    (cu_if)
  );

  // ---------------- reference model ----------------
  function automatic int last_t(input int op);
    case (op)
      0, 2:                               return 7;
      18:                                 return 6;
      1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15: return 5;
      16, 17:                             return 4;
      default:                            return 3;
    endcase
  endfunction

  // ALU one-hot bit named by each arithmetic opcode
  function automatic int alu_bit(input int op);
    case (op)
      3, 11:  return 0;   // ADD
      4:      return 1;   // SUB
      14:     return 2;   // MUL
      15:     return 3;   // DIV
      5:      return 4;   // SHR
      6:      return 5;   // SHL
      7:      return 6;   // ROR
      8:      return 7;   // ROL
      9, 12:  return 8;   // AND
      10, 13: return 9;   // OR
      16:     return 10;  // NEGATE
      17:     return 11;  // NOT
      default: return 0;
    endcase
  endfunction

  function automatic bit is_illegal(input int op);
    return (op == 20) || (op == 23) || (op == 24) || (op >= 27);
  endfunction

  function automatic obs_t active_zero();
    obs_t e;
    e = '0;
    e.run = 1'b1;
    return e;
  endfunction

  function automatic obs_t idle_exp();
    obs_t e;
    e = '0;
    return e;
  endfunction

  function automatic obs_t expect_out(input int op, input int t, input bit con);
    obs_t e;
    bit ldf, ralu, ialu, md, un;
    e = active_zero();
    ldf  = (op <= 2);
    ralu = (op >= 3)  && (op <= 10);
    ialu = (op >= 11) && (op <= 13);
    md   = (op == 14) || (op == 15);
    un   = (op == 16) || (op == 17);
    case (t)
      0: begin e.dr[PCOUT] = 1; e.ld[MARIN] = 1; e.al[A_INCPC] = 1; e.ld[RZIN] = 1; end
      1: begin e.dr[RZOUT] = 1; e.ld[PCIN] = 1; e.rd = 1; e.ld[MDRIN] = 1; end
      2: begin e.dr[MDROUT] = 1; e.ld[IRIN] = 1; end
      3: begin
        if (ldf)              begin e.rs[GRB] = 1; e.dr[BAOUT] = 1; e.ld[RYIN] = 1; end
        else if (ralu || ialu) begin e.rs[GRB] = 1; e.rs[ROUT] = 1; e.ld[RYIN] = 1; end
        else if (md)          begin e.rs[GRA] = 1; e.rs[ROUT] = 1; e.ld[RYIN] = 1; end
        else if (un)          begin e.rs[GRB] = 1; e.rs[ROUT] = 1; e.al[alu_bit(op)] = 1; e.ld[RZIN] = 1; end
        else if (op == 18)    begin e.rs[GRA] = 1; e.rs[ROUT] = 1; e.ld[CONIN] = 1; end
        else if (op == 19)    begin e.rs[GRA] = 1; e.rs[ROUT] = 1; e.ld[PCIN] = 1; end
        else if (op == 21)    begin e.dr[INPUTOUT] = 1; e.rs[GRA] = 1; e.rs[RIN] = 1; end
        else if (op == 22)    begin e.rs[GRA] = 1; e.rs[ROUT] = 1; e.ld[OUTPUTIN] = 1; end
        else if (is_illegal(op)) e.ill = 1;
      end
      4: begin
        if (ldf)            begin e.dr[COUT] = 1; e.al[A_ADD] = 1; e.ld[RZIN] = 1; end
        else if (ralu)      begin e.rs[GRC] = 1; e.rs[ROUT] = 1; e.al[alu_bit(op)] = 1; e.ld[RZIN] = 1; end
        else if (ialu)      begin e.dr[COUT] = 1; e.al[alu_bit(op)] = 1; e.ld[RZIN] = 1; end
        else if (md)        begin e.rs[GRB] = 1; e.rs[ROUT] = 1; e.al[alu_bit(op)] = 1; e.ld[RZIN] = 1; end
        else if (un)        begin e.dr[RZOUT] = 1; e.rs[GRA] = 1; e.rs[RIN] = 1; end
        else if (op == 18)  begin e.dr[PCOUT] = 1; e.ld[RYIN] = 1; end
      end
      5: begin
        if (op == 0 || op == 2)         begin e.dr[RZOUT] = 1; e.ld[MARIN] = 1; end
        else if (op == 1 || ralu || ialu) begin e.dr[RZOUT] = 1; e.rs[GRA] = 1; e.rs[RIN] = 1; end
        else if (md)                    begin e.dr[RZOUT] = 1; e.ld[HILOIN] = 1; end
        else if (op == 18)              begin e.dr[COUT] = 1; e.al[A_ADD] = 1; e.ld[RZIN] = 1; end
      end
      6: begin
        if (op == 0)       begin e.rd = 1; e.ld[MDRIN] = 1; end
        else if (op == 2)  begin e.rs[GRA] = 1; e.rs[ROUT] = 1; e.ld[MDRIN] = 1; end
        else if (op == 18) begin e.dr[RZOUT] = 1; e.ld[PCIN] = con; end
      end
      7: begin
        if (op == 0)       begin e.dr[MDROUT] = 1; e.rs[GRA] = 1; e.rs[RIN] = 1; end
        else if (op == 2)  e.wr = 1;
      end
      default: ;
    endcase
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input obs_t exp);
    obs_t got;
    got.ld  = cu_if.ld_en;
    got.dr  = cu_if.drv_en;
    got.rs  = cu_if.reg_sel;
    got.al  = cu_if.alu_op;
    got.rd  = cu_if.Read;
    got.wr  = cu_if.Write;
    got.run = cu_if.run;
    got.ill = cu_if.illegal_op;
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Runs one instruction from T0. Entry/exit point: 1 time unit after a rising edge, FSM in T0.
  // con_mode: -1 random CON per cycle, else fixed. abort_t: step at which reset is pulsed (-1 none).
  task automatic run_instr(input logic [31:0] instr, input bit stop_end, input int hold,
                           input int con_mode, input int abort_t);
    int op, lt;
    bit con;
    op = int'(instr[31:27]);
    lt = last_t(op);
    for (int t = 0; t <= lt; t++) begin
      con = (con_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(con_mode);
      cu_if.CON  = con;
      cu_if.step = 1'($urandom_range(0, 1));
      cu_if.stop = (t == lt) ? stop_end : 1'($urandom_range(0, 1));
      if (t == abort_t) begin
        rst_n = 1'b0;
        #1;
        chk($sformatf("abort_now_op%0d_t%0d", op, t), active_zero());
        @(negedge clk);
        chk("abort_hold", active_zero());
        @(posedge clk);
        #1;
        chk("abort_after_edge", active_zero());
        rst_n = 1'b1;
        cu_if.stop = 1'b0;
        return;
      end
      @(negedge clk);
      chk($sformatf("op%0d_t%0d", op, t), expect_out(op, t, con));
      @(posedge clk);
      #1;
      if (t == 2) cu_if.IR = instr;
    end
    if (op == 26) begin
      for (int k = 0; k < 5; k++) begin
        cu_if.stop = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("halted", idle_exp());
        @(posedge clk);
        #1;
      end
    end else if (stop_end) begin
      for (int k = 0; k <= hold; k++) begin
        cu_if.stop = (k < hold);
        @(negedge clk);
        chk($sformatf("stopped_%0d", k), idle_exp());
        @(posedge clk);
        #1;
      end
    end
    cu_if.stop = 1'b0;
  endtask

  function automatic logic [31:0] mk(input int op, input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [3:0] rc, input logic [14:0] c);
    return {5'(op), ra, rb, rc, c};
  endfunction

  initial begin
    logic [31:0] r;
    int          op;
    rst_n      = 1'b0;
    cu_if.IR   = '0;
    cu_if.CON  = 1'b0;
    cu_if.stop = 1'b0;
    cu_if.step = 1'b0;
    #3;
    chk("reset", active_zero());
    @(posedge clk);
    #1;
    chk("reset_held_over_edge", active_zero());
    rst_n = 1'b1;

    run_instr(mk(2, 4'd1, 4'd0, 4'd0, 15'h63), 1'b0, 0, -1, -1);  // st R1,0x63(R0)
    run_instr(mk(0, 4'd2, 4'd0, 4'd0, 15'h75), 1'b1, 2, -1, -1);  // ld R2,0x75(R0) then stop
    run_instr(mk(3, 4'd3, 4'd4, 4'd5, 15'h0), 1'b0, 0, -1, -1);   // add R3,R4,R5
    run_instr(mk(14, 4'd4, 4'd5, 4'd0, 15'h0), 1'b0, 0, -1, -1);  // mul R4,R5
    run_instr(mk(18, 4'd6, 4'd0, 4'd0, 15'd4), 1'b0, 0, 1, -1);   // br taken
    run_instr(mk(18, 4'd6, 4'd0, 4'd0, 15'd4), 1'b0, 0, 0, -1);   // br not taken
    run_instr(mk(31, 4'd0, 4'd0, 4'd0, 15'h0), 1'b0, 0, -1, -1);  // illegal 0x1F
    run_instr(mk(25, 4'd0, 4'd0, 4'd0, 15'h0), 1'b1, 0, -1, -1);  // nop, minimal stop

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 31);
      if (op == 26) op = 25;
      r = $urandom();
      run_instr({5'(op), r[26:0]}, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), -1, -1);
    end

    run_instr(mk(2, 4'd1, 4'd0, 4'd0, 15'h63), 1'b0, 0, -1, 6);   // st aborted by reset in T6
    run_instr(mk(3, 4'd1, 4'd2, 4'd3, 15'h0), 1'b0, 0, -1, -1);   // restart from T0
    run_instr(mk(26, 4'd0, 4'd0, 4'd0, 15'h0), 1'b0, 0, -1, -1);  // halt

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
